// File: rtl/manchester_tx.sv
// Manchester / load-modulation transmitter for 106 kbit/s card emulation.
// A frame is LEAD (1 cycle, subcarrier warm-up), SOC (a start bit modulated
// in its first half), one DATA period per bit (1 = loaded first half,
// 0 = loaded second half) and EOC (one unloaded bit period), then done.
// Input bits arrive over a valid/ready handshake into a 1-entry skid
// register, so the next bit can be collected while the current one is
// being modulated.
module manchester_tx #(
    // Carrier cycles per bit period; keep it a multiple of 32 so that each
    // modulated half (BIT_TICKS/2) spans a whole number of fc/16 periods and
    // therefore starts on a rising subcarrier edge.
    parameter int BIT_TICKS = 128
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_data,
    input  logic in_last,
    output logic in_ready,
    input  logic subcarrier,
    output logic sc_en,
    output logic lm_out,
    output logic busy,
    output logic underrun,
    output logic done
);

    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(BIT_TICKS / 2);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEAD = 3'd1;
    localparam logic [2:0] S_SOC  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_EOC  = 3'd4;

    // Registered state
    logic [2:0]    state_q;
    logic [TW-1:0] tick_q;
    logic          skid_full_q;
    logic          skid_data_q;
    logic          skid_last_q;
    logic          cur_data_q;
    logic          cur_last_q;
    logic          last_acc_q;   // the frame's last bit has been taken in
    logic          mod_half_q;   // load during this cycle (before subcarrier gating)

    // Next-state values
    logic [2:0]    state_d;
    logic [TW-1:0] tick_d;
    logic          skid_full_d;
    logic          skid_data_d;
    logic          skid_last_d;
    logic          cur_data_d;
    logic          cur_last_d;
    logic          last_acc_d;
    logic          mod_half_d;

    logic          accept;
    logic          tick_end;
    logic          move;         // skid -> current bit at a bit boundary
    logic          underrun_c;
    logic          done_c;

    assign tick_end = (tick_q == TICK_LAST);
    assign accept   = in_valid && in_ready;

    // Ready: always in IDLE; during SOC/DATA only while there is room in the
    // skid register and the frame's last bit has not yet been collected.
    // Held low while rst is asserted so nothing is taken during reset.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state_q == S_IDLE)
                in_ready = 1'b1;
            else if ((state_q == S_SOC) || (state_q == S_DATA))
                in_ready = !skid_full_q && !last_acc_q;
        end
    end

    // Frame sequencing: next state, tick counter, bit-boundary decisions.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_end ? '0 : tick_q + TW'(1);
        move       = 1'b0;
        underrun_c = 1'b0;
        done_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (accept)
                    state_d = S_LEAD;
            end
            S_LEAD: begin
                tick_d  = '0;
                state_d = S_SOC;
            end
            S_SOC: begin
                if (tick_end) begin
                    move    = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick_end) begin
                    if (cur_last_q) begin
                        state_d = S_EOC;
                    end else if (skid_full_q) begin
                        move = 1'b1;          // next DATA bit, tick wraps to 0
                    end else begin
                        underrun_c = 1'b1;    // nothing queued: close the frame
                        state_d    = S_EOC;
                    end
                end
            end
            S_EOC: begin
                if (tick_end) begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Skid / current-bit datapath. The boundary move is applied first and an
    // accept in the same cycle then writes the freed entry, so a bit is
    // never lost or duplicated when both happen together.
    always_comb begin
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        cur_data_d  = cur_data_q;
        cur_last_d  = cur_last_q;
        last_acc_d  = last_acc_q;

        if (move) begin
            cur_data_d  = skid_data_q;
            cur_last_d  = skid_last_q;
            skid_full_d = 1'b0;
        end

        if (accept) begin
            skid_full_d = 1'b1;
            skid_data_d = in_data;
            skid_last_d = in_last;
            // A new frame starts from a clean last flag.
            last_acc_d  = (state_q == S_IDLE) ? in_last : (last_acc_q | in_last);
        end

        // Leaving the frame: drop anything left over so the next frame
        // starts from an empty buffer.
        if (done_c) begin
            skid_full_d = 1'b0;
            last_acc_d  = 1'b0;
        end
    end

    // Modulation envelope for the cycle after this edge, derived from the
    // state/tick/bit that will be current then, so lm_out lines up exactly
    // with the bit-period boundaries.
    always_comb begin
        mod_half_d = 1'b0;
        case (state_d)
            S_SOC:   mod_half_d = (tick_d < TICK_HALF);
            S_DATA:  mod_half_d = cur_data_d ? (tick_d < TICK_HALF)
                                             : (tick_d >= TICK_HALF);
            default: mod_half_d = 1'b0;
        endcase
    end

    // State registers with synchronous reset; reset aborts any frame at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            skid_full_q <= 1'b0;
            skid_data_q <= 1'b0;
            skid_last_q <= 1'b0;
            cur_data_q  <= 1'b0;
            cur_last_q  <= 1'b0;
            last_acc_q  <= 1'b0;
            mod_half_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            cur_data_q  <= cur_data_d;
            cur_last_q  <= cur_last_d;
            last_acc_q  <= last_acc_d;
            mod_half_q  <= mod_half_d;
        end
    end

    // Status and drive outputs. Pulses are masked during reset so an abort
    // never reports completion or starvation.
    assign busy     = (state_q != S_IDLE);
    assign sc_en    = (state_q == S_LEAD) || (state_q == S_SOC) || (state_q == S_DATA);
    assign underrun = underrun_c && !rst;
    assign done     = done_c && !rst;

    // Load modulation is the envelope gated by the subcarrier, nothing else.
    assign lm_out   = mod_half_q & subcarrier;

endmodule

// File: tb/tb_manchester_tx.sv
// Randomized scoreboard bench for manchester_tx. The driver queues a frame
// description (bits, count, starvation) before sending it; the monitor pops
// it when the frame starts (busy rises) and checks every cycle of the frame
// against a timeline computed from bit-period arithmetic.
module tb_manchester_tx;

    localparam int BT   = 128;
    localparam int HALF = BT / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_data = 1'b0;
    logic in_last = 1'b0;
    logic subcarrier;
    logic in_ready, sc_en, lm_out, busy, underrun, done;

    always #5 clk = ~clk;

    manchester_tx #(.BIT_TICKS(BT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .subcarrier(subcarrier),
        .sc_en(sc_en), .lm_out(lm_out), .busy(busy),
        .underrun(underrun), .done(done)
    );

    // External fc/16 subcarrier generator: first high cycle is one tick
    // after sc_en asserts, 8 high / 8 low.
    logic       sc_run = 1'b0;
    logic [3:0] sc_ph  = 4'd0;
    always @(posedge clk) begin
        sc_run <= sc_en;
        if (sc_en) sc_ph <= sc_run ? sc_ph + 4'd1 : 4'd0;
        else       sc_ph <= 4'd0;
    end
    assign subcarrier = sc_run && !sc_ph[3];

    typedef struct {
        logic [31:0] bits;
        int          n;       // bits actually delivered
        bit          starve;  // frame ends through underrun
    } frame_t;

    frame_t exp_q[$];
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit mon_active = 1'b0;

    task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
        end
    endtask

    // Monitor: per-cycle comparison against the frame timeline.
    // t=0 is the LEAD cycle; SOC is t=1..BT; bit k (1-based) occupies
    // t=k*BT+1..(k+1)*BT; EOC follows for BT cycles.
    initial begin
        frame_t f;
        int tend, tsc, acc, seg, w;
        bit e_mod, e_sub, e_lm, e_sc, e_busy, e_done, e_und;
        forever begin
            @(negedge clk); #1;
            if (mon_en && busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 0, 1, 0);
                end else begin
                    f = exp_q.pop_front();
                    mon_active = 1'b1;
                    tsc  = (f.n + 1) * BT;
                    tend = (f.n + 2) * BT;
                    acc  = 0;
                    for (int t = 0; t <= tend + 1; t++) begin
                        if (t > 0) begin @(negedge clk); #1; end
                        e_busy = (t <= tend);
                        e_sc   = (t <= tsc);
                        e_done = (t == tend);
                        e_und  = f.starve && (t == tsc);
                        e_mod  = 1'b0;
                        if (t >= 1 && t <= tsc) begin
                            seg = (t - 1) / BT;
                            w   = (t - 1) % BT;
                            if (seg == 0) e_mod = (w < HALF);
                            else          e_mod = f.bits[seg-1] ? (w < HALF) : (w >= HALF);
                        end
                        e_sub = (t >= 1) && (((t - 1) % 16) < 8);
                        e_lm  = e_mod && e_sub;
                        check("frame {lm,sc_en,busy,done,underrun}", t,
                              {27'd0, lm_out, sc_en, busy, done, underrun},
                              {27'd0, e_lm, e_sc, e_busy, e_done, e_und});
                        if (t == 0 || (t > tsc && t <= tend))
                            check("in_ready in LEAD/EOC", t, {31'd0, in_ready}, 32'd0);
                        if (t <= tend && in_valid && in_ready) acc++;
                    end
                    check("accepts during frame", tend, acc, f.n - 1);
                    mon_active = 1'b0;
                end
            end
        end
    end

    // Driver: send `stop` of the `n` planned bits; stop < n starves the DUT.
    task automatic send_frame(input logic [31:0] bits, input int n, input int stop);
        frame_t f;
        int w;
        f.bits = bits; f.n = stop; f.starve = (stop < n);
        exp_q.push_back(f);
        for (int i = 0; i < stop; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = bits[i]; in_last = (i == n - 1);
            w = 0;
            while (!in_ready && w < 3000) begin @(negedge clk); w++; end
            if (w >= 3000) begin
                check("handshake timeout", i, 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        if (f.starve) begin
            in_valid = 1'b0;
            for (int k = 0; k < 5000 && busy; k++) @(negedge clk);
        end else begin
            // Keep offering a junk bit through LEAD/DATA/EOC; none may be taken.
            in_data = 1'($urandom); in_last = 1'b0;
            for (int k = 0; k < 5000 && !done; k++) @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_monitor_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || mon_active) && k < 10000) begin @(negedge clk); k++; end
        if (k >= 10000) check("monitor drain timeout", k, 0, 1);
        @(negedge clk); @(negedge clk); #2;
    endtask

    // Abort a frame with rst during DATA tick 40.
    task automatic reset_mid_frame();
        bit seen;
        wait_monitor_idle();
        mon_en = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = 1'b1; in_last = 1'b0;
        @(negedge clk);                         // LEAD, t=0
        in_data = 1'b0;
        check("rst test frame started", 0, {31'd0, busy}, 32'd1);
        repeat (BT + 41) @(negedge clk);        // DATA bit 1, tick 40
        check("rst test mid-frame {sc_en,busy}", 40, {30'd0, sc_en, busy}, 32'd3);
        rst = 1'b1; in_valid = 1'b0;
        #1;
        check("during rst {in_ready,done,underrun}", 40, {29'd0, in_ready, done, underrun}, 32'd0);
        @(negedge clk);
        check("after rst {sc_en,lm_out,busy,done,underrun}", 41,
              {27'd0, sc_en, lm_out, busy, done, underrun}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready after rst release", 41, {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (2 * BT) begin
            @(negedge clk);
            if (done || busy || underrun || lm_out) seen = 1'b1;
        end
        check("no activity after abort", 0, {31'd0, seen}, 32'd0);
        mon_en = 1'b1;
    endtask

    initial begin
        int n, stop;
        logic [31:0] bits;

        // Reset state, with in_valid asserted to make sure nothing is taken.
        rst = 1'b1; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("reset {sc_en,lm_out,busy,underrun,done,in_ready}", 0,
              {26'd0, sc_en, lm_out, busy, underrun, done, in_ready}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("idle after reset {in_ready,busy}", 0, {30'd0, in_ready, busy}, 32'd2);
        mon_en = 1'b1;

        send_frame(32'b1, 1, 1);                // single 1, last
        repeat (3) @(negedge clk);
        send_frame(32'b010, 3, 3);              // 0,1,0 back-to-back
        send_frame(32'b1011, 4, 2);             // starve after bit 2 of 4
        send_frame(32'b0110, 4, 1);             // starve after bit 1
        reset_mid_frame();

        for (int f = 0; f < 12; f++) begin
            n    = $urandom_range(1, 6);
            bits = $urandom;
            stop = n;
            if (n >= 2 && $urandom_range(0, 3) == 0) stop = $urandom_range(1, n - 1);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send_frame(bits, n, stop);
        end

        wait_monitor_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
